// File: rtl/pulse_pkg.sv
// Shared types and defaults for the fast-domain pulse pacer and its integration.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    GAP  = 2'd2
  } pacer_state_t;

  localparam int MIN_GAP_DEFAULT = 8;
  localparam int CNT_W_DEFAULT   = 4;

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down backlog counter; an increment at full scale is dropped and flagged.
module pend_counter #(
  parameter int CNT_W = 4
) (
  input  logic             fclk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             sat_drop
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Simultaneous inc and dec cancel, so a full counter can still accept that event.
  assign sat_drop = inc && !dec && (cnt_reg == PEND_MAX);

  always_comb begin
    cnt_next = cnt_reg;
    if (inc && !dec && (cnt_reg != PEND_MAX)) begin
      cnt_next = cnt_reg + 1'b1;
    end else if (dec && !inc && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge fclk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/pulse_pacer.sv
// Paces raw fast-domain events into 1-cycle pulses spaced MIN_GAP cycles apart
// so each one survives the downstream fast->slow->fast pulse synchronizer.
module pulse_pacer
  import pulse_pkg::*;
#(
  parameter int MIN_GAP = MIN_GAP_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic             fclk,
  input  logic             reset,
  input  logic             en,
  input  logic             ev_in,
  input  logic             clr_ovf,
  output logic             f_pulse,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             overflow,
  output logic             busy
);

  localparam int GAP_W = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 2);

  generate
    if (MIN_GAP < 2) begin : g_bad_gap
      $error("pulse_pacer: MIN_GAP must be at least 2");
    end
  endgenerate

  pacer_state_t     state_reg, state_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic             overflow_reg;
  logic             fire_start;
  logic             sat_drop;

  pend_counter #(
    .CNT_W (CNT_W)
  ) u_pend (
    .fclk     (fclk),
    .reset    (reset),
    .inc      (ev_in),
    .dec      (fire_start),
    .cnt      (pend_cnt),
    .sat_drop (sat_drop)
  );

  always_comb begin
    state_next   = state_reg;
    gap_cnt_next = gap_cnt_reg;
    fire_start   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en && (pend_cnt != '0)) begin
          state_next = FIRE;
          fire_start = 1'b1;
        end
      end
      FIRE: begin
        state_next   = GAP;
        gap_cnt_next = GAP_LOAD;
      end
      GAP: begin
        if (gap_cnt_reg != '0) begin
          gap_cnt_next = gap_cnt_reg - 1'b1;
        end else if (en && (pend_cnt != '0)) begin
          state_next = FIRE;
          fire_start = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge fclk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      gap_cnt_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gap_cnt_reg <= gap_cnt_next;
      // A drop on the same edge as a clear keeps the flag set.
      if (sat_drop) begin
        overflow_reg <= 1'b1;
      end else if (clr_ovf) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign f_pulse  = (state_reg == FIRE);
  assign overflow = overflow_reg;
  assign busy     = (state_reg != IDLE) || (pend_cnt != '0);

endmodule
